// File: rtl/regfile_dump_if.sv
// Controller <-> register file / debug stream bundle.
// The master side is the dump/clear controller.
interface regfile_dump_if;
   logic        Start;
   logic        Mode;
   logic [4:0]  FirstReg;
   logic [4:0]  LastReg;
   logic [31:0] BusA;
   logic [4:0]  RA;
   logic [4:0]  RB;
   logic [4:0]  RW;
   logic [31:0] BusW;
   logic        RegWr;
   logic [31:0] DumpData;
   logic [4:0]  DumpIdx;
   logic        DumpValid;
   logic        DumpReady;
   logic        DumpLast;
   logic        Busy;
   logic        Done;
   logic        RangeErr;

   modport master (
      input  Start, Mode, FirstReg, LastReg, BusA, DumpReady,
      output RA, RB, RW, BusW, RegWr, DumpData, DumpIdx, DumpValid, DumpLast,
             Busy, Done, RangeErr
   );

   modport slave (
      output Start, Mode, FirstReg, LastReg, BusA, DumpReady,
      input  RA, RB, RW, BusW, RegWr, DumpData, DumpIdx, DumpValid, DumpLast,
             Busy, Done, RangeErr
   );
endinterface

// File: rtl/regfile_dump_ctrl.sv
// Register file dump/clear initiator: streams a register range out over
// valid/ready, or writes CLEAR_VALUE across a range one register per cycle.
module regfile_dump_ctrl #(
   parameter int unsigned READ_WAIT   = 1,
   parameter logic [31:0] CLEAR_VALUE = 32'h0
) (
   input logic            Clk,
   input logic            Reset_n,
   regfile_dump_if.master bus
);
   typedef enum logic [2:0] {IDLE, RD_WAIT, RD_VALID, CLR, FIN} state_t;

   localparam logic [2:0] WAIT_END = 3'(READ_WAIT - 1);

   state_t      state, state_n;
   logic [4:0]  idx, idx_n, last, last_n;
   logic [2:0]  wcnt, wcnt_n;
   logic [4:0]  ra, ra_n, rw, rw_n, dump_idx, dump_idx_n;
   logic [31:0] busw, busw_n, dump_data, dump_data_n;
   logic        regwr, regwr_n, dump_valid, dump_valid_n, dump_last, dump_last_n;
   logic        done, done_n, range_err, range_err_n;

   // Every file-facing output is a flop so it is settled before the
   // file's falling-edge write, and drops with the async reset.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state      <= IDLE;
         idx        <= '0;
         last       <= '0;
         wcnt       <= '0;
         ra         <= '0;
         rw         <= '0;
         busw       <= '0;
         regwr      <= 1'b0;
         dump_data  <= '0;
         dump_idx   <= '0;
         dump_valid <= 1'b0;
         dump_last  <= 1'b0;
         done       <= 1'b0;
         range_err  <= 1'b0;
      end else begin
         state      <= state_n;
         idx        <= idx_n;
         last       <= last_n;
         wcnt       <= wcnt_n;
         ra         <= ra_n;
         rw         <= rw_n;
         busw       <= busw_n;
         regwr      <= regwr_n;
         dump_data  <= dump_data_n;
         dump_idx   <= dump_idx_n;
         dump_valid <= dump_valid_n;
         dump_last  <= dump_last_n;
         done       <= done_n;
         range_err  <= range_err_n;
      end
   end

   always_comb begin
      state_n      = state;
      idx_n        = idx;
      last_n       = last;
      wcnt_n       = wcnt;
      ra_n         = ra;
      rw_n         = rw;
      busw_n       = busw;
      regwr_n      = 1'b0;
      dump_data_n  = dump_data;
      dump_idx_n   = dump_idx;
      dump_valid_n = dump_valid;
      dump_last_n  = dump_last;
      done_n       = 1'b0;
      range_err_n  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.Start) begin
               idx_n  = bus.FirstReg;
               last_n = bus.LastReg;
               wcnt_n = '0;
               if (bus.FirstReg > bus.LastReg) begin
                  state_n     = FIN;
                  done_n      = 1'b1;
                  range_err_n = 1'b1;
               end else if (!bus.Mode) begin
                  state_n = RD_WAIT;
                  ra_n    = bus.FirstReg;
               end else begin
                  // r0 is hardwired in the file, so it is never written
                  state_n = CLR;
                  rw_n    = bus.FirstReg;
                  busw_n  = CLEAR_VALUE;
                  regwr_n = (bus.FirstReg != 5'd0);
               end
            end
         end
         RD_WAIT: begin
            if (wcnt == WAIT_END) begin
               wcnt_n       = '0;
               dump_data_n  = bus.BusA;
               dump_idx_n   = idx;
               dump_last_n  = (idx == last);
               dump_valid_n = 1'b1;
               state_n      = RD_VALID;
            end else begin
               wcnt_n = wcnt + 3'd1;
            end
         end
         RD_VALID: begin
            if (bus.DumpReady) begin
               dump_valid_n = 1'b0;
               if (dump_last) begin
                  state_n = FIN;
                  done_n  = 1'b1;
               end else begin
                  idx_n   = idx + 5'd1;
                  ra_n    = idx + 5'd1;
                  state_n = RD_WAIT;
               end
            end
         end
         CLR: begin
            // index never wraps: stop at last, which may be 31
            if (idx == last) begin
               state_n = FIN;
               done_n  = 1'b1;
            end else begin
               idx_n   = idx + 5'd1;
               rw_n    = idx + 5'd1;
               regwr_n = 1'b1;
            end
         end
         FIN:     state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   assign bus.RA        = ra;
   assign bus.RB        = 5'd0;
   assign bus.RW        = rw;
   assign bus.BusW      = busw;
   assign bus.RegWr     = regwr;
   assign bus.DumpData  = dump_data;
   assign bus.DumpIdx   = dump_idx;
   assign bus.DumpValid = dump_valid;
   assign bus.DumpLast  = dump_last;
   assign bus.Busy      = (state != IDLE);
   assign bus.Done      = done;
   assign bus.RangeErr  = range_err;
endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Bench for regfile_dump_ctrl: behavioural 32x32 file with falling-edge
// writes, dump beats checked against a queue of expected beats.
module tb_regfile_dump_ctrl;
   typedef struct {
      logic [4:0]  idx;
      logic [31:0] data;
      logic        last;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] rf     [32];
   logic [31:0] exp_rf [32];
   beat_t       sb [$];

   int n_checks = 0, n_errs = 0;
   int wr_cnt = 0, done_cnt = 0, hs_cnt = 0, dv_cnt = 0;
   logic        stalled = 1'b0;
   logic [31:0] sv_data;
   logic [4:0]  sv_idx;
   logic        sv_last;

   regfile_dump_if bus();

   regfile_dump_ctrl #(.READ_WAIT(1), .CLEAR_VALUE(32'h0)) dut (
      .Clk(clk), .Reset_n(rst_n), .bus(bus)
   );

   always #5 clk = ~clk;

   assign bus.BusA = (bus.RA == 5'd0) ? 32'h0 : rf[bus.RA];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock: observe/act at the falling edge, return 1ns after the rising edge.
   task automatic step();
      beat_t b;
      @(negedge clk);
      if (bus.RegWr) begin
         wr_cnt++;
         chk("wr_addr_nonzero", 32'(bus.RW != 5'd0), 1);
         rf[bus.RW] = bus.BusW;
      end
      if (bus.Done) done_cnt++;
      if (bus.RangeErr) chk("rerr_with_done", 32'(bus.Done), 1);
      if (bus.DumpValid) begin
         dv_cnt++;
         if (stalled) begin
            chk("stall_data", bus.DumpData, sv_data);
            chk("stall_idx", 32'(bus.DumpIdx), 32'(sv_idx));
            chk("stall_last", 32'(bus.DumpLast), 32'(sv_last));
         end
         if (bus.DumpReady) begin
            hs_cnt++;
            stalled = 1'b0;
            if (sb.size() == 0) chk("sb_underflow", 1, 0);
            else begin
               b = sb.pop_front();
               chk("beat_idx", 32'(bus.DumpIdx), 32'(b.idx));
               chk("beat_data", bus.DumpData, b.data);
               chk("beat_last", 32'(bus.DumpLast), 32'(b.last));
            end
         end else begin
            stalled = 1'b1;
            sv_data = bus.DumpData;
            sv_idx  = bus.DumpIdx;
            sv_last = bus.DumpLast;
         end
      end else stalled = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic push_dump(input int f, input int l);
      for (int i = f; i <= l; i++) sb.push_back('{5'(i), exp_rf[i], i == l});
   endtask

   task automatic start_op(input logic m, input logic [4:0] f, input logic [4:0] l);
      bus.Mode = m; bus.FirstReg = f; bus.LastReg = l; bus.Start = 1'b1;
      step();
      bus.Start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input logic [3:0] pat, output int n);
      int d0 = done_cnt;
      n = 0;
      while (done_cnt == d0 && n < budget) begin
         bus.DumpReady = pat[n % 4];
         step();
         n++;
      end
      chk("done_timeout", 32'(done_cnt != d0), 1);
   endtask

   initial begin
      int n, d0, h0, w0, v0;
      rst_n = 1'b0;
      bus.Start = 1'b0; bus.Mode = 1'b0; bus.FirstReg = '0; bus.LastReg = '0;
      bus.DumpReady = 1'b0;
      rf[0] = 32'h0; exp_rf[0] = 32'h0;
      for (int i = 1; i < 32; i++) begin
         rf[i] = 32'hA500_0000 + 32'(i);
         exp_rf[i] = rf[i];
      end
      rf[5] = 32'hDEADBEEF; exp_rf[5] = 32'hDEADBEEF;
      rf[6] = 32'h12345678; exp_rf[6] = 32'h12345678;
      step(); step();
      chk("rst_busy", 32'(bus.Busy), 0);
      chk("rst_dv", 32'(bus.DumpValid), 0);
      chk("rst_regwr", 32'(bus.RegWr), 0);
      chk("rst_done", 32'(bus.Done), 0);
      chk("rst_ra", 32'(bus.RA), 0);
      chk("rst_rb", 32'(bus.RB), 0);
      rst_n = 1'b1;
      step();

      // dump 5..6, ready held high
      d0 = done_cnt; h0 = hs_cnt;
      bus.DumpReady = 1'b1;
      push_dump(5, 6);
      start_op(1'b0, 5'd5, 5'd6);
      chk("t1_busy", 32'(bus.Busy), 1);
      chk("t1_dv_early", 32'(bus.DumpValid), 0);
      chk("t1_ra", 32'(bus.RA), 5);
      step();
      chk("t1_dv_2cyc", 32'(bus.DumpValid), 1);
      wait_done(20, 4'b1111, n);
      step(); step();
      chk("t1_hs", 32'(hs_cnt - h0), 2);
      chk("t1_done", 32'(done_cnt - d0), 1);
      chk("t1_sb", 32'(sb.size()), 0);
      chk("t1_idle", 32'(bus.Busy), 0);

      // dump 0..2 with ready pattern 1,0,0,1
      d0 = done_cnt; h0 = hs_cnt;
      push_dump(0, 2);
      start_op(1'b0, 5'd0, 5'd2);
      wait_done(60, 4'b1001, n);
      step(); step();
      chk("t2_hs", 32'(hs_cnt - h0), 3);
      chk("t2_done", 32'(done_cnt - d0), 1);
      chk("t2_sb", 32'(sb.size()), 0);

      // clear 0..31 over all-ones contents
      bus.DumpReady = 1'b0;
      for (int i = 1; i < 32; i++) rf[i] = 32'hFFFF_FFFF;
      d0 = done_cnt; w0 = wr_cnt; v0 = dv_cnt;
      start_op(1'b1, 5'd0, 5'd31);
      wait_done(60, 4'b0000, n);
      chk("t3_cycles", 32'(n), 33);
      step(); step();
      chk("t3_writes", 32'(wr_cnt - w0), 31);
      chk("t3_done", 32'(done_cnt - d0), 1);
      chk("t3_no_dv", 32'(dv_cnt - v0), 0);
      for (int i = 1; i < 32; i++) exp_rf[i] = 32'h0;
      for (int i = 0; i < 32; i++) chk("t3_mem", rf[i], exp_rf[i]);

      // inverted range
      d0 = done_cnt; w0 = wr_cnt; v0 = dv_cnt;
      start_op(1'b0, 5'd9, 5'd3);
      chk("t4_done", 32'(bus.Done), 1);
      chk("t4_rerr", 32'(bus.RangeErr), 1);
      step(); step();
      chk("t4_done_pulse", 32'(bus.Done), 0);
      chk("t4_rerr_pulse", 32'(bus.RangeErr), 0);
      chk("t4_cnt", 32'(done_cnt - d0), 1);
      chk("t4_no_wr", 32'(wr_cnt - w0), 0);
      chk("t4_no_dv", 32'(dv_cnt - v0), 0);
      chk("t4_idle", 32'(bus.Busy), 0);

      // dump 30..31, stray Start while busy
      rf[30] = 32'h3030_3030; exp_rf[30] = rf[30];
      rf[31] = 32'h3131_3131; exp_rf[31] = rf[31];
      d0 = done_cnt; h0 = hs_cnt; w0 = wr_cnt;
      bus.DumpReady = 1'b1;
      push_dump(30, 31);
      start_op(1'b0, 5'd30, 5'd31);
      bus.Mode = 1'b1; bus.FirstReg = 5'd0; bus.LastReg = 5'd1; bus.Start = 1'b1;
      step(); step();
      bus.Start = 1'b0;
      wait_done(20, 4'b1111, n);
      step(); step(); step();
      chk("t5_hs", 32'(hs_cnt - h0), 2);
      chk("t5_done", 32'(done_cnt - d0), 1);
      chk("t5_no_wr", 32'(wr_cnt - w0), 0);
      chk("t5_sb", 32'(sb.size()), 0);
      chk("t5_idle", 32'(bus.Busy), 0);

      // reset during clear at index 10
      bus.DumpReady = 1'b0;
      for (int i = 1; i < 32; i++) begin
         rf[i] = 32'h5A5A_0000 + 32'(i);
         exp_rf[i] = rf[i];
      end
      d0 = done_cnt;
      start_op(1'b1, 5'd1, 5'd31);
      n = 0;
      while (!(bus.RegWr && bus.RW == 5'd10) && n < 40) begin
         step();
         n++;
      end
      chk("t6_reach10", 32'(bus.RW), 10);
      rst_n = 1'b0;
      #1;
      chk("t6_regwr_async", 32'(bus.RegWr), 0);
      chk("t6_busy_async", 32'(bus.Busy), 0);
      chk("t6_rw_async", 32'(bus.RW), 0);
      step(); step();
      rst_n = 1'b1;
      step(); step();
      chk("t6_idle", 32'(bus.Busy), 0);
      chk("t6_no_done", 32'(done_cnt - d0), 0);
      for (int i = 1; i < 10; i++) exp_rf[i] = 32'h0;
      for (int i = 1; i < 32; i++) chk("t6_mem", rf[i], exp_rf[i]);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end
endmodule
